text_frame_writer: RTL and testbench

- Producer for the write side of the ASCII double buffer.
- Accepts character and cursor commands from the CPU over a valid/ready interface and writes formatted 32-bit cells into the back buffer.
- On COMMIT it waits for vertical blank, pulses switch_buffer, then auto-clears the new back buffer.
- Sits between the CPU I/O register block and double_buffer's write_address/write_data/switch_buffer inputs.

---
 rtl/text_frame_writer.sv | 131 +++++++++++++
 tb/tb_text_frame_writer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/text_frame_writer.sv
// text_frame_writer: formats CPU text commands into back-buffer cells, swaps on vblank, then clears
module text_frame_writer #(
   parameter int          COLS   = 80,
   parameter int          ROWS   = 60,
   parameter logic [7:0]  DEF_FG = 8'hFF,
   parameter logic [7:0]  DEF_BG = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_arg,
   input  logic        vsync_start,
   output logic [12:0] write_address,
   output logic [31:0] write_data,
   output logic        switch_buffer,
   output logic        busy,
   output logic [7:0]  frame_count
);
   localparam logic [6:0]  CMAX  = 7'(COLS - 1);
   localparam logic [5:0]  RMAX  = 6'(ROWS - 1);
   localparam logic [12:0] NMAX  = 13'(COLS * ROWS - 1);
   localparam logic [12:0] COLSW = 13'(COLS);
   typedef enum logic [2:0] {IDLE, WAIT_VS, SWITCH, GAP, CLEAR} state_t;
   state_t      state, state_n;
   logic [6:0]  col, col_n;
   logic [5:0]  row, row_n;
   logic [12:0] lin, lin_n, k, k_n, wa_n;
   logic [7:0]  fg, fg_n, bg, bg_n, fc_n;
   logic [31:0] wd_n;
   logic        gap, gap_n, sw_n;
   assign cmd_ready = state == IDLE;
   assign busy      = state != IDLE;
   // next-state, cursor and cell-write decisions
   always_comb begin
      state_n = state;
      col_n   = col;
      row_n   = row;
      lin_n   = lin;
      k_n     = k;
      fg_n    = fg;
      bg_n    = bg;
      fc_n    = frame_count;
      wa_n    = write_address;
      wd_n    = write_data;
      gap_n   = gap;
      sw_n    = 1'b0;
      case (state)
         IDLE: if (cmd_valid) case (cmd_op)
            2'd0: if (cmd_arg[7:0] != 8'h0A) begin
               wa_n  = lin;
               wd_n  = {8'h00, bg, fg, cmd_arg[7:0]};
               col_n = (col == CMAX) ? 7'd0 : col + 7'd1;
               row_n = (col != CMAX) ? row : (row == RMAX) ? 6'd0 : row + 6'd1;
               lin_n = (col == CMAX && row == RMAX) ? 13'd0 : lin + 13'd1;
            end else begin
               col_n = 7'd0;
               row_n = (row == RMAX) ? 6'd0 : row + 6'd1;
               lin_n = {7'd0, row_n} * COLSW;
            end
            2'd1: begin
               col_n = (cmd_arg[6:0] > CMAX) ? CMAX : cmd_arg[6:0];
               row_n = (cmd_arg[13:8] > RMAX) ? RMAX : cmd_arg[13:8];
               lin_n = {7'd0, row_n} * COLSW + {6'd0, col_n};
            end
            2'd2: begin
               fg_n = cmd_arg[7:0];
               bg_n = cmd_arg[15:8];
            end
            default: state_n = WAIT_VS;
         endcase
         WAIT_VS: if (vsync_start) begin
            state_n = SWITCH;
            sw_n    = 1'b1;
            fc_n    = frame_count + 8'd1;
         end
         SWITCH: begin
            state_n = GAP;
            gap_n   = 1'b0;
         end
         GAP: begin
            gap_n   = 1'b1;
            state_n = gap ? CLEAR : GAP;
            k_n     = 13'd0;
         end
         CLEAR: begin
            wa_n = k;
            wd_n = {8'h00, bg, fg, 8'h20};
            k_n  = (k == NMAX) ? 13'd0 : k + 13'd1;
            if (k == NMAX) begin
               col_n   = 7'd0;
               row_n   = 6'd0;
               lin_n   = 13'd0;
               state_n = IDLE;
            end
         end
         default: state_n = CLEAR;
      endcase
   end
   // state and registered outputs; reset lands in CLEAR so the buffer starts blank
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= CLEAR;
         col           <= 7'd0;
         row           <= 6'd0;
         lin           <= 13'd0;
         k             <= 13'd0;
         fg            <= DEF_FG;
         bg            <= DEF_BG;
         frame_count   <= 8'd0;
         write_address <= 13'd0;
         write_data    <= 32'd0;
         gap           <= 1'b0;
         switch_buffer <= 1'b0;
      end else begin
         state         <= state_n;
         col           <= col_n;
         row           <= row_n;
         lin           <= lin_n;
         k             <= k_n;
         fg            <= fg_n;
         bg            <= bg_n;
         frame_count   <= fc_n;
         write_address <= wa_n;
         write_data    <= wd_n;
         gap           <= gap_n;
         switch_buffer <= sw_n;
      end
   end
endmodule

// File: tb/tb_text_frame_writer.sv
// tb_text_frame_writer: random and directed command stream against a cursor/phase reference model
module tb_text_frame_writer;
   localparam int COLS = 80, ROWS = 60, N = COLS * ROWS;
   localparam int M_IDLE = 0, M_WAIT = 1, M_SW = 2, M_GAP = 3, M_CLR = 4;
   logic        clk = 0, rst = 0, cmd_valid = 0, vsync_start = 0;
   logic [1:0]  cmd_op = 0;
   logic [15:0] cmd_arg = 0;
   logic        cmd_ready, switch_buffer, busy;
   logic [12:0] write_address;
   logic [31:0] write_data;
   logic [7:0]  frame_count;
   int          checks = 0, passes = 0;
   int          ph = M_CLR, mk = 0, mg = 0, mcol = 0, mrow = 0;
   logic [7:0]  mfg = 8'hFF, mbg = 8'h00, efc = 0;
   logic [12:0] ewa = 0;
   logic [31:0] ewd = 0;
   logic        esw = 0;

   text_frame_writer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .vsync_start(vsync_start),
      .write_address(write_address), .write_data(write_data),
      .switch_buffer(switch_buffer), .busy(busy), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // reference model: cursor as (col,row), cell address derived as row*COLS+col
   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         ph = M_CLR; mk = 0; mcol = 0; mrow = 0; mfg = 8'hFF; mbg = 8'h00;
         ewa = 0; ewd = 0; efc = 0; esw = 0;
      end else begin
         esw = 0;
         case (ph)
            M_IDLE: if (cmd_valid) case (cmd_op)
               2'd0: if (cmd_arg[7:0] == 8'h0A) begin
                  mcol = 0; mrow = (mrow + 1) % ROWS;
               end else begin
                  ewa = 13'(mrow * COLS + mcol);
                  ewd = {8'h00, mbg, mfg, cmd_arg[7:0]};
                  mcol++;
                  if (mcol == COLS) begin mcol = 0; mrow = (mrow + 1) % ROWS; end
               end
               2'd1: begin
                  mcol = (int'(cmd_arg[6:0]) > COLS - 1) ? COLS - 1 : int'(cmd_arg[6:0]);
                  mrow = (int'(cmd_arg[13:8]) > ROWS - 1) ? ROWS - 1 : int'(cmd_arg[13:8]);
               end
               2'd2: begin mfg = cmd_arg[7:0]; mbg = cmd_arg[15:8]; end
               default: ph = M_WAIT;
            endcase
            M_WAIT: if (vsync_start) begin ph = M_SW; esw = 1; efc++; end
            M_SW: begin ph = M_GAP; mg = 2; end
            M_GAP: begin mg--; if (mg == 0) begin ph = M_CLR; mk = 0; end end
            default: begin
               ewa = 13'(mk); ewd = {8'h00, mbg, mfg, 8'h20}; mk++;
               if (mk == N) begin mcol = 0; mrow = 0; ph = M_IDLE; end
            end
         endcase
      end
   end

   // every-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      chk("addr", write_address, ewa);
      chk("data", write_data, ewd);
      chk("switch", switch_buffer, esw);
      chk("frames", frame_count, efc);
      chk("busy", busy, ph != M_IDLE);
      chk("ready", cmd_ready, ph == M_IDLE);
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [15:0] arg);
      cmd_valid = 1; cmd_op = op; cmd_arg = arg;
      step();
      cmd_valid = 0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 20000) begin step(); n++; end
   endtask

   initial begin
      int n, commits;
      logic [7:0] r;
      repeat (3) @(posedge clk); #1;
      chk("rst_addr", write_address, 0);
      chk("rst_data", write_data, 0);
      chk("rst_busy_ready_sw", {busy, cmd_ready, switch_buffer}, 3'b100);
      rst = 1;
      wait_idle(n);
      chk("init_clear_len", n, 4800);
      chk("init_last_addr", write_address, 4799);
      chk("init_last_data", write_data, 32'h0000FF20);
      chk("init_ready", cmd_ready, 1);
      send(2'd1, 16'h0205);
      send(2'd0, 16'h0041);
      chk("putc_addr", write_address, 165);
      chk("putc_data", write_data, 32'h0000FF41);
      send(2'd0, 16'h0042);
      chk("putc_next_addr", write_address, 166);
      send(2'd1, 16'h3B4F);
      send(2'd0, 16'h0042);
      chk("last_cell_addr", write_address, 4799);
      send(2'd0, 16'h0043);
      chk("wrap_addr", write_address, 0);
      send(2'd2, 16'h031C);
      send(2'd0, 16'h000A);
      chk("newline_no_write", write_address, 0);
      send(2'd0, 16'h005A);
      chk("nl_addr", write_address, 80);
      chk("nl_data", write_data, 32'h00031C5A);
      send(2'd3, 16'h0000);
      for (int i = 0; i < 100; i++) begin
         step();
         chk("wait_vs_hold", {busy, cmd_ready, switch_buffer}, 3'b100);
      end
      vsync_start = 1; step(); vsync_start = 0;
      chk("switch_pulse", switch_buffer, 1);
      chk("frame_one", frame_count, 1);
      step();
      chk("switch_drop", switch_buffer, 0);
      chk("gap_hold_addr", write_address, 80);
      wait_idle(n);
      chk("commit_clear_len", n, 4802);
      chk("commit_last_data", write_data, 32'h00031C20);
      commits = 0;
      for (int i = 0; i < 3000; i++) begin
         r = 8'($urandom_range(0, 99));
         cmd_valid = 1'($urandom);
         cmd_arg = 16'($urandom);
         cmd_op = (r < 45) ? 2'd0 : (r < 70) ? 2'd1 : (r < 97) ? 2'd2 : (commits < 4) ? 2'd3 : 2'd0;
         if (cmd_op == 2'd3) commits++;
         if (cmd_op == 2'd0 && r[0]) cmd_arg[7:0] = 8'h0A;
         vsync_start = ($urandom_range(0, 15) == 0);
         step();
      end
      cmd_valid = 0;
      vsync_start = 1; step(); vsync_start = 0;
      wait_idle(n);
      chk("random_settle", busy, 0);
      send(2'd3, 16'h0000);
      vsync_start = 1; step(); vsync_start = 0;
      n = 0;
      while (!(ph == M_CLR && write_address == 1000) && n < 6000) begin step(); n++; end
      chk("reach_k1000", write_address, 1000);
      #2 rst = 0;
      #1;
      chk("midclr_rst_addr", write_address, 0);
      chk("midclr_rst_data", write_data, 0);
      chk("midclr_rst_frames", frame_count, 0);
      chk("midclr_rst_flags", {busy, cmd_ready, switch_buffer}, 3'b100);
      step();
      rst = 1;
      step();
      chk("restart_addr", write_address, 0);
      chk("restart_data", write_data, 32'h0000FF20);
      wait_idle(n);
      chk("restart_len", n, 4799);
      chk("restart_frames", frame_count, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
